// File: rtl/led_avalon_driver.sv
// led_avalon_driver: Avalon-MM slave that receives LED commands from the
// Nios II master and drives the board LEDs with hardware blink and global
// PWM brightness.
//
// Ports:
//   clk               system clock
//   reset             asynchronous, active-high reset
//   avs_address       word address: 0 DATA, 1 BLINK_MASK, 2 BLINK_PERIOD, 3 DUTY
//   avs_write         write strobe, one cycle per transfer
//   avs_writedata     write data
//   avs_read          read strobe, one cycle per transfer
//   avs_readdata      read data, holds its last value between reads
//   avs_readdatavalid one-cycle pulse when avs_readdata carries a new value
//   leds              registered LED drive, 1 = lit ([17:0] LEDR, [25:18] LEDG)
module led_avalon_driver #(
    parameter int NUM_LEDS = 26,
    parameter int PWM_BITS = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic                avs_readdatavalid,
    output logic [NUM_LEDS-1:0] leds
);

    logic [NUM_LEDS-1:0] r_data;
    logic [NUM_LEDS-1:0] r_mask;
    logic [PERIOD_W-1:0] r_period;
    logic [PWM_BITS-1:0] r_duty;

    logic [PERIOD_W-1:0] r_blink_cnt;
    logic                r_blink_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    // First read stage: data is captured from the pre-write register values,
    // so a read and write to the same address in one cycle returns old data.
    logic                r_rd_pend;
    logic [31:0]         r_rd_buf;

    logic [31:0]         w_rd_val;
    logic                w_pwm_on;
    logic                w_period_wr;

    assign w_period_wr = avs_write && (avs_address == 2'd2);

    // Full duty is forced on so there is no dark cycle when pwm_cnt wraps.
    assign w_pwm_on = (r_duty == '1) || (r_pwm_cnt < r_duty);

    always_comb begin
        w_rd_val = '0;
        case (avs_address)
            2'd0:    w_rd_val = 32'(r_data);
            2'd1:    w_rd_val = 32'(r_mask);
            2'd2:    w_rd_val = 32'(r_period);
            default: w_rd_val = 32'(r_duty);
        endcase
    end

    // Register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_mask   <= '0;
            r_period <= '0;
            r_duty   <= '1;
        end else if (avs_write) begin
            case (avs_address)
                2'd0:    r_data   <= avs_writedata[NUM_LEDS-1:0];
                2'd1:    r_mask   <= avs_writedata[NUM_LEDS-1:0];
                2'd2:    r_period <= avs_writedata[PERIOD_W-1:0];
                default: r_duty   <= avs_writedata[PWM_BITS-1:0];
            endcase
        end
    end

    // Read pipeline: request captured at edge N, presented after edge N+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend         <= 1'b0;
            r_rd_buf          <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            r_rd_pend         <= avs_read;
            if (avs_read)
                r_rd_buf      <= w_rd_val;
            avs_readdatavalid <= r_rd_pend;
            if (r_rd_pend)
                avs_readdata  <= r_rd_buf;
        end
    end

    // Blink timer: each phase lasts exactly BLINK_PERIOD cycles. A write to
    // BLINK_PERIOD restarts the timer, so lowering the period never overruns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_period_wr || (r_period == '0)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == r_period - PERIOD_W'(1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + PERIOD_W'(1);
        end
    end

    // Free-running PWM counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end

    // Blinking bits are blanked during the low phase (blink_phase = 0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            leds <= '0;
        else
            leds <= r_data & ~(r_mask & {NUM_LEDS{~r_blink_phase}})
                           & {NUM_LEDS{w_pwm_on}};
    end

endmodule

// File: tb/tb_led_avalon_driver.sv
// Self-checking bench for led_avalon_driver. Read expectations are queued
// when a read is issued and popped when readdatavalid is observed.
module tb_led_avalon_driver;

    localparam int NUM_LEDS = 26;

    logic                clk;
    logic                reset;
    logic [1:0]          avs_address;
    logic                avs_write;
    logic [31:0]         avs_writedata;
    logic                avs_read;
    logic [31:0]         avs_readdata;
    logic                avs_readdatavalid;
    logic [NUM_LEDS-1:0] leds;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q[$];

    led_avalon_driver #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(8),
        .PERIOD_W(24)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_address      (avs_address),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_read         (avs_read),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .leds             (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write at edge N; returns 1 ns after edge N.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write     = 1'b0;
    endtask

    // Read sampled at edge N; reports valid after N, N+1, N+2 and data after N+1.
    task automatic bus_read(input logic [1:0] addr, input logic [31:0] expv,
                            output logic v0, output logic v1,
                            output logic [31:0] d, output logic v2);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        v0 = avs_readdatavalid;
        @(posedge clk);
        #1;
        v1 = avs_readdatavalid;
        d  = avs_readdata;
        @(posedge clk);
        #1;
        v2 = avs_readdatavalid;
    endtask

    task automatic test_reset;
        logic v0, v1, v2;
        logic [31:0] d, e;
        logic [31:0] rst_vals [4];
        rst_vals[0] = 32'h0;
        rst_vals[1] = 32'h0;
        rst_vals[2] = 32'h0;
        rst_vals[3] = 32'hFF;
        n_tests++;
        if (leds !== '0 || avs_readdata !== 32'h0 || avs_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: leds=%h rd=%h rdv=%b, want 0/0/0",
                     leds, avs_readdata, avs_readdatavalid);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned a = 0; a < 4; a++) begin
            bus_read(2'(a), rst_vals[a], v0, v1, d, v2);
            e = exp_q.pop_front();
            n_tests++;
            if (v0 !== 1'b0 || v1 !== 1'b1 || v2 !== 1'b0 || d !== e || leds !== '0) begin
                n_fail++;
                $display("FAIL reset_read%0d: rdv=%b%b%b data=%h leds=%h, want rdv=010 data=%h leds=0",
                         a, v0, v1, v2, d, leds, e);
            end
        end
    endtask

    task automatic test_data_steady;
        int unsigned bad;
        bus_write(2'd0, 32'h03FF_FFFF);
        n_tests++;
        if (leds !== '0) begin
            n_fail++;
            $display("FAIL data_latency_early: leds=%h, want 0", leds);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (leds !== 26'h3FF_FFFF) begin
            n_fail++;
            $display("FAIL data_latency: leds=%h, want 3ffffff", leds);
        end
        bad = 0;
        for (int unsigned c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (leds !== 26'h3FF_FFFF) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_duty_no_gap: %0d cycles differed from 3ffffff, want 0", bad);
        end
    endtask

    task automatic test_blink;
        logic expb;
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h4);
        for (int unsigned k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            expb = (((k - 1) / 4) % 2) == 0;
            n_tests++;
            if (leds[0] !== expb || leds[NUM_LEDS-1:1] !== '0) begin
                n_fail++;
                $display("FAIL blink_k%0d: leds=%h, want leds[0]=%b", k, leds, expb);
            end
        end
        bus_write(2'd2, 32'h0);
        for (int unsigned k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (leds[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL blink_off_k%0d: leds[0]=%b, want 1", k, leds[0]);
            end
        end
    endtask

    task automatic test_pwm;
        int unsigned on_cnt;
        logic v0, v1, v2;
        logic [31:0] d, e;
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h1);
        bus_write(2'd3, 32'h40);
        on_cnt = 0;
        for (int unsigned c = 0; c < 256; c++) begin
            @(posedge clk);
            #1;
            if (leds[0] === 1'b1) on_cnt++;
        end
        n_tests++;
        if (on_cnt != 64) begin
            n_fail++;
            $display("FAIL pwm_duty40: on %0d of 256, want 64", on_cnt);
        end
        bus_read(2'd3, 32'h40, v0, v1, d, v2);
        e = exp_q.pop_front();
        n_tests++;
        if (v1 !== 1'b1 || d !== e) begin
            n_fail++;
            $display("FAIL duty_readback: rdv=%b data=%h, want 1 %h", v1, d, e);
        end
        bus_write(2'd3, 32'h0);
        on_cnt = 0;
        for (int unsigned c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (leds[0] === 1'b1) on_cnt++;
        end
        n_tests++;
        if (on_cnt != 0) begin
            n_fail++;
            $display("FAIL pwm_duty0: on %0d cycles, want 0", on_cnt);
        end
        bus_write(2'd3, 32'hFF);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, 32'h03FF_FFFF, v0, v1, d, v2);
        e = exp_q.pop_front();
        n_tests++;
        if (v1 !== 1'b1 || d !== e) begin
            n_fail++;
            $display("FAIL unused_bits: data=%h, want %h", d, e);
        end
    endtask

    task automatic test_same_cycle;
        logic v0, v1, v2;
        logic [31:0] d, e;
        bus_write(2'd0, 32'hA);
        @(negedge clk);
        avs_address   = 2'd0;
        avs_writedata = 32'h5;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        exp_q.push_back(32'hA);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (avs_readdatavalid !== 1'b1 || avs_readdata !== e) begin
            n_fail++;
            $display("FAIL rw_same_cycle: rdv=%b data=%h, want 1 %h",
                     avs_readdatavalid, avs_readdata, e);
        end
        bus_read(2'd0, 32'h5, v0, v1, d, v2);
        e = exp_q.pop_front();
        n_tests++;
        if (v1 !== 1'b1 || d !== e) begin
            n_fail++;
            $display("FAIL rw_followup: data=%h, want %h", d, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        bus_write(2'd1, 32'h0155_5555);
        @(negedge clk);
        avs_address = 2'd0;
        avs_read    = 1'b1;
        exp_q.push_back(32'h5);
        @(posedge clk);
        #1;
        avs_address = 2'd1;
        exp_q.push_back(32'h0155_5555);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (avs_readdatavalid !== 1'b1 || avs_readdata !== e) begin
                n_fail++;
                $display("FAIL b2b_read%0d: rdv=%b data=%h, want 1 %h",
                         i, avs_readdatavalid, avs_readdata, e);
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (avs_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tail: rdv=%b, want 0", avs_readdatavalid);
        end
    endtask

    task automatic test_reset_mid;
        logic v0, v1, v2;
        logic [31:0] d, e;
        logic [31:0] rst_vals [4];
        int unsigned bad;
        rst_vals[0] = 32'h0;
        rst_vals[1] = 32'h0;
        rst_vals[2] = 32'h0;
        rst_vals[3] = 32'hFF;
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h4);
        @(posedge clk);
        #1;
        @(negedge clk);
        avs_address = 2'd0;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (leds[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_blink: leds[0]=%b, want 1", leds[0]);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (leds !== '0 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: leds=%h rdv=%b rd=%h, want 0/0/0",
                     leds, avs_readdatavalid, avs_readdata);
        end
        avs_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (avs_readdatavalid !== 1'b0 || leds !== '0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dropped_read: %0d cycles with rdv or leds set, want 0", bad);
        end
        for (int unsigned a = 0; a < 4; a++) begin
            bus_read(2'(a), rst_vals[a], v0, v1, d, v2);
            e = exp_q.pop_front();
            n_tests++;
            if (v1 !== 1'b1 || d !== e) begin
                n_fail++;
                $display("FAIL post_reset_read%0d: rdv=%b data=%h, want 1 %h", a, v1, d, e);
            end
        end
        // With period 0 the phase must sit at 1, so a masked bit stays lit.
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'h1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (leds !== 26'h1) begin
            n_fail++;
            $display("FAIL post_reset_phase: leds=%h, want 0000001", leds);
        end
    endtask

    initial begin
        reset         = 1'b1;
        avs_address   = 2'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        avs_read      = 1'b0;
        #2;
        test_reset();
        test_data_steady();
        test_blink();
        test_pwm();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_avalon_driver.md
Name: led_avalon_driver

Overview:
Avalon-MM slave (responder) that receives LED commands from the Nios II master and drives the board LEDs. It sits in the nios_system fabric beside the key PIO and carries data in the opposite direction, CPU to board LEDR[17:0]/LEDG[7:0]. It adds hardware blink and global PWM brightness, so software writes a pattern once and does not bit-bang.

Parameters:
NUM_LEDS, 26, LED outputs; bits [17:0] = LEDR, [25:18] = LEDG at top level
PWM_BITS, 8, brightness resolution
PERIOD_W, 24, blink half-period counter width (max ~0.33 s at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high
avs_address  input  2  register select
avs_write  input  1  write strobe, one cycle per transfer
avs_writedata  input  32  write data
avs_read  input  1  read strobe, one cycle per transfer
avs_readdata  output  32  read data
avs_readdatavalid  output  1  high one cycle when avs_readdata is valid
leds  output  NUM_LEDS  registered LED drive, 1 = lit

Behaviour:
- One clock; reset is asynchronous and active-high. All state clears immediately on reset assertion. Release is synchronous to clk.
- No waitrequest. Every transfer is accepted in the cycle it is presented.
- Register map (word address), all read/write. Unused bits write-ignored, read 0:
  0 DATA [NUM_LEDS-1:0]: on/off pattern
  1 BLINK_MASK [NUM_LEDS-1:0]: 1 = bit blinks
  2 BLINK_PERIOD [PERIOD_W-1:0]: half-period in clk cycles; 0 = blink disabled
  3 DUTY [PWM_BITS-1:0]: global brightness
- Reset values:
  - DATA=0, BLINK_MASK=0, BLINK_PERIOD=0, DUTY=all ones.
  - leds=0, avs_readdata=0, avs_readdatavalid=0.
  - blink_cnt=0, blink_phase=1, pwm_cnt=0.
- Write: the register updates at the clock edge where avs_write=1.
- Read:
  - avs_read=1 at edge N → avs_readdata holds the register value and avs_readdatavalid=1 after edge N+1, for exactly one cycle.
  - avs_readdata holds its last value otherwise.
- Read and write to the same address in the same cycle: read returns the pre-write value.
- Blink timer:
  - When BLINK_PERIOD=P>0, blink_cnt counts 0..P-1.
  - At P-1: blink_cnt←0 and blink_phase toggles. One phase therefore lasts exactly P cycles.
  - When P=0: blink_cnt held 0, blink_phase held 1.
  - Any write to BLINK_PERIOD sets blink_cnt←0 and blink_phase←1 on that edge.
  - If P is lowered below the current count, the write-triggered clear already resynchronises the timer, so no overrun occurs.
- PWM:
  - pwm_cnt is free-running, 0..2^PWM_BITS-1, and wraps to 0.
  - pwm_on = (DUTY == all ones) OR (pwm_cnt < DUTY).
  - DUTY=0 → always off. DUTY=all ones → always on, with no one-cycle gap at wrap.
- Output, registered: leds ← DATA & ~(BLINK_MASK & {NUM_LEDS{~blink_phase}}) & {NUM_LEDS{pwm_on}}.
  - leds reflects a register write one cycle after the write edge.
  - leds reflects blink_phase/pwm_cnt one cycle after they change.
- Writes to address 2 or 3 do not alter DATA/BLINK_MASK. Writes to DATA do not disturb the timers.
- Reset mid-operation: outputs go 0 asynchronously. A read in flight is dropped, so no readdatavalid appears after reset.

Test Plan:
- Reset, then read addresses 0–3 → readdata 0x0, 0x0, 0x0, 0xFF respectively, each with readdatavalid high exactly 1 cycle after avs_read. leds=0 throughout.
- Write DATA=0x3FFFFFF at edge N → leds=0x3FFFFFF from edge N+1. Stays constant with DUTY=0xFF; no PWM gap across a pwm_cnt wrap.
- DATA=0x1, BLINK_MASK=0x1, BLINK_PERIOD=4 → leds[0] high 4 cycles, low 4 cycles, repeating. Write BLINK_PERIOD=0 → leds[0] steady high.
- DUTY=0x40, DATA=0x1 → leds[0] high 64 of every 256 cycles. DUTY=0 → leds[0] never high.
- Same-cycle write DATA=0x5 plus read of address 0 (old DATA 0xA) → readdata=0xA. The next read returns 0x5.
- Assert reset mid-blink with avs_read active → leds=0 and readdatavalid=0 immediately. After release, registers return to reset values and blink_phase=1.
